// File: rtl/uart_rx_os.sv
// UART receiver: oversampled 3-sample majority vote, 5..8 data bits, optional
// parity, 1/2 stop bits, noise/break detection and a small valid/ready FIFO.
module uart_rx_os #(
  parameter int p_clk_speed_hz = 50_000_000,
  parameter int p_baud_rate    = 9_600,
  parameter int p_oversample   = 16,
  parameter int p_fifo_depth   = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       enable_i,
  input  logic       data_i,
  input  logic [1:0] data_bits_i,
  input  logic       parity_en_i,
  input  logic       parity_sel_i,
  input  logic       stop2_i,
  input  logic       err_clr_i,
  input  logic       rd_ready_i,
  output logic       rd_valid_o,
  output logic [7:0] rd_data_o,
  output logic       rd_parity_err_o,
  output logic       rd_framing_err_o,
  output logic       rd_noise_err_o,
  output logic       busy_o,
  output logic       break_o,
  output logic       overrun_o
);

  localparam int DIV = p_clk_speed_hz / (p_baud_rate * p_oversample);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(p_oversample);
  localparam int AW  = $clog2(p_fifo_depth);

  localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);
  localparam logic [OW-1:0] OS_S0  = OW'(p_oversample / 2 - 1);
  localparam logic [OW-1:0] OS_S1  = OW'(p_oversample / 2);
  localparam logic [OW-1:0] OS_S2  = OW'(p_oversample / 2 + 1);
  localparam logic [OW-1:0] OS_END = OW'(p_oversample - 1);
  localparam logic [AW:0]   FULL   = (AW + 1)'(p_fifo_depth);

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_os: clock too slow for baud rate * oversample");
  end
  if ((p_oversample < 8) || (p_oversample % 2 != 0)) begin : g_bad_os
    $error("uart_rx_os: p_oversample must be even and >= 8");
  end
  if ((p_fifo_depth < 2) || ((1 << AW) != p_fifo_depth)) begin : g_bad_depth
    $error("uart_rx_os: p_fifo_depth must be a power of two >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, rx_s_q;
  logic [DW-1:0]   div_cnt_q;
  logic [OW-1:0]   os_cnt_q;
  logic [2:0]      smp_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      data_q;
  logic [1:0]      data_bits_q;
  logic            parity_en_q, parity_sel_q, stop2_q;
  logic            par_err_q, frm_err_q, noise_q, zero_q, stop_cnt_q;
  logic            break_q, overrun_q;
  logic [10:0]     mem_q [p_fifo_depth];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  function automatic logic split3(input logic [2:0] s);
    return (|s) & ~(&s);
  endfunction

  logic       tick, start_det, end_tick, mid_tick, last_bit;
  logic [2:0] smp_mid;
  logic       vote_end, noise_end, vote_mid, noise_mid;
  logic       push, brk, do_pop, do_wr;
  logic [10:0] entry, head;

  assign tick      = (div_cnt_q == DIV_M1);
  assign start_det = (state_q == S_IDLE) && !rx_s_q && enable_i;
  assign end_tick  = tick && (os_cnt_q == OS_END);
  assign mid_tick  = tick && (os_cnt_q == OS_S2);
  assign last_bit  = (bit_cnt_q == ({1'b0, data_bits_q} + 3'd4));
  // At the third sample tick the newest sample is still on rx_s, not yet in smp_q.
  assign smp_mid   = {rx_s_q, smp_q[1:0]};
  assign vote_end  = maj3(smp_q);
  assign noise_end = split3(smp_q);
  assign vote_mid  = maj3(smp_mid);
  assign noise_mid = split3(smp_mid);

  // Two-flop synchroniser on the async line; idles high.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= data_i;
      rx_s_q  <= sync1_q;
    end
  end

  // Prescaler and oversample counter; both realign to the start edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_cnt_q <= '0;
      os_cnt_q  <= '0;
      smp_q     <= '0;
    end else if (start_det) begin
      div_cnt_q <= '0;
      os_cnt_q  <= '0;
    end else if (tick) begin
      div_cnt_q <= '0;
      os_cnt_q  <= (os_cnt_q == OS_END) ? '0 : os_cnt_q + 1'b1;
      if (os_cnt_q == OS_S0) smp_q[0] <= rx_s_q;
      if (os_cnt_q == OS_S1) smp_q[1] <= rx_s_q;
      if (os_cnt_q == OS_S2) smp_q[2] <= rx_s_q;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state; stop bits resolve at mid-bit so the receiver resyncs half a bit early.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    brk     = 1'b0;
    unique case (state_q)
      S_IDLE:   if (start_det) state_d = S_START;
      S_START:  if (end_tick) state_d = vote_end ? S_IDLE : S_DATA;
      S_DATA:   if (end_tick && last_bit) state_d = parity_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (end_tick) state_d = S_STOP;
      S_STOP: begin
        if (mid_tick) begin
          if (!stop_cnt_q && !vote_mid && zero_q) begin
            brk     = 1'b1;
            state_d = S_BREAK;
          end else if (stop_cnt_q || !stop2_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_BREAK:  if (rx_s_q) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Frame datapath: config latch, bit assembly and per-frame error flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_bits_q  <= '0;
      parity_en_q  <= 1'b0;
      parity_sel_q <= 1'b0;
      stop2_q      <= 1'b0;
      data_q       <= '0;
      bit_cnt_q    <= '0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      noise_q      <= 1'b0;
      zero_q       <= 1'b0;
      stop_cnt_q   <= 1'b0;
    end else if (start_det) begin
      data_bits_q  <= data_bits_i;
      parity_en_q  <= parity_en_i;
      parity_sel_q <= parity_sel_i;
      stop2_q      <= stop2_i;
      data_q       <= '0;
      bit_cnt_q    <= '0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      noise_q      <= 1'b0;
      zero_q       <= 1'b1;
      stop_cnt_q   <= 1'b0;
    end else begin
      if (end_tick && (state_q == S_START)) noise_q <= noise_q | noise_end;
      if (end_tick && (state_q == S_DATA)) begin
        data_q[bit_cnt_q] <= vote_end;
        bit_cnt_q         <= bit_cnt_q + 1'b1;
        noise_q           <= noise_q | noise_end;
        zero_q            <= zero_q & ~vote_end;
      end
      if (end_tick && (state_q == S_PARITY)) begin
        par_err_q <= vote_end ^ (^data_q) ^ parity_sel_q;
        noise_q   <= noise_q | noise_end;
        zero_q    <= zero_q & ~vote_end;
      end
      if (mid_tick && (state_q == S_STOP)) begin
        noise_q    <= noise_q | noise_mid;
        frm_err_q  <= frm_err_q | ~vote_mid;
        stop_cnt_q <= 1'b1;
      end
    end
  end

  // The last stop vote is folded in directly since it is not yet registered.
  assign entry  = {noise_q | noise_mid, frm_err_q | ~vote_mid, par_err_q, data_q};
  assign do_pop = rd_valid_o && rd_ready_i;
  assign do_wr  = push && ((cnt_q != FULL) || do_pop);

  // FIFO storage; contents are only visible while the entry is valid.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= entry;
  end

  // FIFO pointers, occupancy, sticky overrun and break pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      break_q   <= 1'b0;
    end else begin
      if (do_wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_wr && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_wr && do_pop) cnt_q <= cnt_q - 1'b1;
      if (push && !do_wr) overrun_q <= 1'b1;
      else if (err_clr_i) overrun_q <= 1'b0;
      break_q <= brk;
    end
  end

  assign head             = mem_q[rd_ptr_q];
  assign rd_valid_o       = (cnt_q != '0);
  assign rd_data_o        = rd_valid_o ? head[7:0] : 8'h00;
  assign rd_parity_err_o  = rd_valid_o & head[8];
  assign rd_framing_err_o = rd_valid_o & head[9];
  assign rd_noise_err_o   = rd_valid_o & head[10];
  assign busy_o           = (state_q != S_IDLE);
  assign break_o          = break_q;
  assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at 1.6 MHz / 10 kBd / 16x (160 clocks per bit).
module tb_uart_rx_os;
  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       data = 1'b1;
  logic [1:0] data_bits = 2'b11;
  logic       parity_en = 1'b0;
  logic       parity_sel = 1'b0;
  logic       stop2 = 1'b0;
  logic       err_clr = 1'b0;
  logic       rd_ready = 1'b0;
  logic       rd_valid, rd_parity_err, rd_framing_err, rd_noise_err, busy, brk, overrun;
  logic [7:0] rd_data;

  int n_chk = 0;
  int n_err = 0;
  int brk_cnt;

  uart_rx_os #(
    .p_clk_speed_hz(1_600_000), .p_baud_rate(10_000), .p_oversample(16), .p_fifo_depth(4)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .data_i(data),
    .data_bits_i(data_bits), .parity_en_i(parity_en), .parity_sel_i(parity_sel),
    .stop2_i(stop2), .err_clr_i(err_clr), .rd_ready_i(rd_ready),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_parity_err_o(rd_parity_err),
    .rd_framing_err_o(rd_framing_err), .rd_noise_err_o(rd_noise_err),
    .busy_o(busy), .break_o(brk), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] db, input logic pe, input logic ps, input logic s2);
    data_bits = db; parity_en = pe; parity_sel = ps; stop2 = s2;
  endtask

  // Drives one frame cycle by cycle; 'spike' inverts the line for that single cycle.
  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pe,
                            input logic pbit, input int nstop, input logic stopv,
                            input int spike);
    logic [15:0] fb;
    int nb;
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < nbits; i++) fb[1+i] = d[i];
    nb = 1 + nbits;
    if (pe) begin fb[nb] = pbit; nb++; end
    fb[nb] = stopv;
    nb += nstop;
    @(posedge clk); #1;
    for (int c = 0; c < nb * BIT; c++) begin
      data = fb[c / BIT] ^ (c == spike);
      @(posedge clk); #1;
    end
    data = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    #1;
  endtask

  task automatic pop();
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
  endtask

  task automatic head(input string tag, input logic [7:0] d, input logic p,
                      input logic f, input logic n);
    chk({tag, ".valid"}, rd_valid, 1);
    chk({tag, ".data"}, rd_data, d);
    chk({tag, ".par"}, rd_parity_err, p);
    chk({tag, ".frm"}, rd_framing_err, f);
    chk({tag, ".noise"}, rd_noise_err, n);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", rd_valid, 0);
    chk("rst.data", rd_data, 0);
    chk("rst.busy", busy, 0);
    chk("rst.break", brk, 0);
    chk("rst.overrun", overrun, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // 8N1 0xA5, held until popped
    cfg(2'b11, 0, 0, 0);
    send_frame(8'hA5, 8, 0, 0, 1, 1, -1);
    head("a5", 8'hA5, 0, 0, 0);
    repeat (50) @(posedge clk);
    #1;
    chk("a5.hold", rd_valid, 1);
    pop();
    chk("a5.popped", rd_valid, 0);

    // 7E2 0x35 (four ones -> even parity bit 0), sent with parity bit 1
    cfg(2'b10, 1, 0, 1);
    send_frame(8'h35, 7, 1, 1, 2, 1, -1);
    head("7e2", 8'h35, 1, 0, 0);
    pop();

    // 5 data bits 0x1F
    cfg(2'b00, 0, 0, 0);
    send_frame(8'h1F, 5, 0, 0, 1, 1, -1);
    head("5b", 8'h1F, 0, 0, 0);
    pop();

    // stop bit low with non-zero data -> framing error, not break
    cfg(2'b11, 0, 0, 0);
    send_frame(8'h5A, 8, 0, 0, 1, 0, -1);
    head("frm", 8'h5A, 0, 1, 0);
    pop();
    repeat (BIT) @(posedge clk);
    #1;
    chk("frm.empty", rd_valid, 0);

    // 40-clock glitch -> false start
    @(posedge clk); #1;
    data = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("glitch.busy", busy, 1);
    repeat (30) @(posedge clk);
    #1;
    data = 1'b1;
    repeat (130) @(posedge clk);
    #1;
    chk("glitch.idle", busy, 0);
    chk("glitch.nopush", rd_valid, 0);
    repeat (BIT) @(posedge clk);

    // single-clock spike landing on the middle sample of data bit 3
    send_frame(8'h00, 8, 0, 0, 1, 1, 730);
    head("noise", 8'h00, 0, 0, 1);
    pop();

    // break: line low for 12 bit times
    brk_cnt = 0;
    @(posedge clk); #1;
    data = 1'b0;
    for (int c = 0; c < 12 * BIT; c++) begin
      @(posedge clk); #1;
      if (brk) brk_cnt++;
    end
    chk("brk.busy", busy, 1);
    data = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("brk.pulses", brk_cnt, 1);
    chk("brk.idle", busy, 0);
    chk("brk.nopush", rd_valid, 0);

    // overrun: 5 frames into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 8, 0, 0, 1, 1, -1);
    chk("ovr.set", overrun, 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("ovr.clr", overrun, 0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovr.head%0d", i), rd_data, 8'(i));
      pop();
    end
    chk("ovr.empty", rd_valid, 0);

    // async reset in the middle of a frame
    send_frame(8'h77, 8, 0, 0, 1, 1, -1);
    chk("arst.pre", rd_valid, 1);
    @(posedge clk); #1;
    data = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("arst.busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy0", busy, 0);
    chk("arst.valid0", rd_valid, 0);
    chk("arst.data0", rd_data, 0);
    data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(8'h3C, 8, 0, 0, 1, 1, -1);
    head("after", 8'h3C, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
